mem_stage_data_memory: RTL

//   MIPS MEM stage data memory plus load/store lane logic.

---
 rtl/mem_stage_data_memory.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_stage_data_memory.sv
// MIPS MEM-stage data memory: four byte lanes with byte-enabled stores, registered
// right-justified loads, misalignment detection and a registered debug read port.

module mem_stage_data_memory_lane #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [7:0]       rdata,
  output logic [7:0]       dbg_data
);
  logic [7:0] mem [1<<IDX_W];

  // No reset on storage: contents survive i_reset.
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata    = mem[idx];
  assign dbg_data = mem[dbg_idx];
endmodule

module mem_stage_data_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10,
  parameter int NB_MASK = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_MASK-1:0] i_mascara,
  input  logic               i_is_unsigned,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic [NB_MASK-1:0] o_mascara,
  output logic               o_is_unsigned,
  output logic               o_valid,
  output logic               o_misaligned,
  input  logic [NB_ADDR-3:0] i_debug_addr,
  output logic [NB_DATA-1:0] o_debug_data
);
  localparam int NUM_LANES = NB_DATA / 8;

  logic [NB_ADDR-3:0]         widx;
  logic [1:0]                 lane;
  logic                       accepted, is_store, is_load, aligned;
  logic [NUM_LANES-1:0]       be;
  logic [NUM_LANES-1:0][7:0]  wdata, rword, dword;
  logic [NB_DATA-1:0]         ld_data;

  assign widx     = i_addr[NB_ADDR-1:2];
  assign lane     = i_addr[1:0];
  assign accepted = i_enable & i_valid & (i_mem_read | i_mem_write);
  assign is_store = i_mem_write;
  assign is_load  = i_mem_read & ~i_mem_write;

  always_comb begin
    aligned = 1'b1;
    be      = '0;
    wdata   = i_wr_data;
    ld_data = rword;
    case (i_mascara)
      2'b00: begin
        be      = 4'b0001 << lane;
        wdata   = {4{i_wr_data[7:0]}};
        ld_data = {24'b0, rword[lane]};
      end
      2'b01: begin
        aligned = ~i_addr[0];
        be      = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{i_wr_data[15:0]}};
        ld_data = i_addr[1] ? {16'b0, rword[3:2]} : {16'b0, rword[1:0]};
      end
      default: begin
        // 2'b10 is reserved and behaves as a word access.
        aligned = (lane == 2'b00);
        be      = 4'b1111;
      end
    endcase
  end

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      mem_stage_data_memory_lane #(.IDX_W(NB_ADDR-2)) u_lane (
        .clk      (i_clock),
        .we       (accepted & is_store & aligned & be[k] & ~i_reset),
        .idx      (widx),
        .wdata    (wdata[k]),
        .dbg_idx  (i_debug_addr),
        .rdata    (rword[k]),
        .dbg_data (dword[k])
      );
    end
  endgenerate

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_rd_data     <= '0;
      o_mascara     <= '0;
      o_is_unsigned <= 1'b0;
      o_valid       <= 1'b0;
      o_misaligned  <= 1'b0;
    end else if (i_enable) begin
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
      if (accepted) begin
        o_mascara     <= i_mascara;
        o_is_unsigned <= i_is_unsigned;
        if (!aligned) begin
          o_misaligned <= 1'b1;
          o_rd_data    <= '0;
        end else if (is_load) begin
          o_rd_data <= ld_data;
          o_valid   <= 1'b1;
        end
      end
    end
  end

  // Debug port ignores i_enable so a halted pipeline can still be inspected.
  always_ff @(posedge i_clock) begin
    if (i_reset) o_debug_data <= '0;
    else         o_debug_data <= dword;
  end
endmodule
